// File: rtl/fetch_sequencer.sv
// Fetch run controller: shares the instruction memory port between the boot loader
// and the fetch path, sequences PC init/update, and stops on HALT_INSTR or budget.
module fetch_sequencer #(
   parameter int unsigned ADDR_W     = 10,
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HALT_INSTR = 32'h0000_000C,
   parameter logic [31:0] MAX_INSTR  = 32'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stall,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic              ld_last,
   input  logic [31:0]       ld_addr,
   input  logic [31:0]       ld_data,
   input  logic [31:0]       cur_pc,
   input  logic [31:0]       instr,
   output logic [ADDR_W-1:0] im_addr,
   output logic              im_we,
   output logic [31:0]       im_wdata,
   output logic              pc_init,
   output logic              pc_we,
   output logic [1:0]        state,
   output logic              halted,
   output logic              timeout,
   output logic              ld_err,
   output logic [31:0]       instr_count
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_LOAD = 2'b01;
   localparam logic [1:0] S_RUN  = 2'b10;
   localparam logic [1:0] S_HALT = 2'b11;

   logic [1:0]  state_q, state_d;
   logic        init_q, init_d;
   logic        timeout_q, timeout_d;
   logic        lderr_q, lderr_d;
   logic [31:0] count_q, count_d;
   logic        addr_ok;

   assign addr_ok = (ld_addr[31:ADDR_W+2] == '0);

   // RESET_PC is applied by the PC register itself; this block only strobes pc_init.
   logic unused_ok;
   assign unused_ok = ^{ld_addr[1:0], cur_pc[31:ADDR_W+2], cur_pc[1:0], RESET_PC};

   always_comb begin
      state_d   = state_q;
      init_d    = init_q;
      timeout_d = timeout_q;
      lderr_d   = lderr_q;
      count_d   = count_q;
      ld_ready  = 1'b0;
      im_we     = 1'b0;
      im_addr   = cur_pc[ADDR_W+1:2];
      im_wdata  = '0;
      pc_init   = 1'b0;
      pc_we     = 1'b0;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (ld_valid) begin
               state_d = S_LOAD;
            end else if (start) begin
               state_d = S_RUN;
               init_d  = 1'b1;
            end
         end
         S_LOAD: begin
            ld_ready = 1'b1;
            im_addr  = ld_addr[ADDR_W+1:2];
            im_wdata = ld_data;
            if (ld_valid) begin
               if (addr_ok) im_we = 1'b1;
               else         lderr_d = 1'b1;
               if (ld_last) state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (init_q) begin
               pc_init   = 1'b1;
               init_d    = 1'b0;
               count_d   = '0;
               timeout_d = 1'b0;
            end else if (!stall) begin
               if (instr == HALT_INSTR) begin
                  state_d = S_HALT;
               end else begin
                  pc_we = 1'b1;
                  if (count_q != '1) count_d = count_q + 32'd1;
                  // Budget compares against the post-retire count; wrap at saturation cannot match.
                  if ((MAX_INSTR != '0) && (count_q + 32'd1 == MAX_INSTR)) begin
                     state_d   = S_HALT;
                     timeout_d = 1'b1;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         init_q    <= 1'b0;
         timeout_q <= 1'b0;
         lderr_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         init_q    <= init_d;
         timeout_q <= timeout_d;
         lderr_q   <= lderr_d;
         count_q   <= count_d;
      end
   end

   assign state       = state_q;
   assign halted      = (state_q == S_HALT);
   assign timeout     = timeout_q;
   assign ld_err      = lderr_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the IM and PC register, scoreboards IM writes and
// retired PCs through queues, and checks load, range error, halt, stall and budget paths.
module tb_fetch_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] HALT_W   = 32'h0000_000C;

   logic        clk = 1'b0;
   logic        rst, start, stall, ld_valid, ld_last;
   logic [31:0] ld_addr, ld_data, instr;
   logic [31:0] cur_pc = '0;
   logic [9:0]  im_addr;
   logic        im_we, ld_ready, pc_init, pc_we, halted, timeout, ld_err;
   logic [31:0] im_wdata, instr_count;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;
   logic [31:0] mem [0:1023];
   logic [41:0] wq[$];
   logic [31:0] rq[$];
   logic [41:0] we_exp;
   logic [31:0] rt_exp;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .ADDR_W(10), .RESET_PC(RESET_PC), .HALT_INSTR(HALT_W), .MAX_INSTR(32'd8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_last(ld_last),
      .ld_addr(ld_addr), .ld_data(ld_data), .cur_pc(cur_pc), .instr(instr),
      .im_addr(im_addr), .im_we(im_we), .im_wdata(im_wdata),
      .pc_init(pc_init), .pc_we(pc_we), .state(state), .halted(halted),
      .timeout(timeout), .ld_err(ld_err), .instr_count(instr_count)
   );

   assign instr = mem[im_addr];

   always @(posedge clk) begin
      if (im_we) mem[im_addr] <= im_wdata;
      if (pc_init)    cur_pc <= RESET_PC;
      else if (pc_we) cur_pc <= cur_pc + 32'd4;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (im_we) begin
            chk("wr_pending", 32'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
               we_exp = wq.pop_front();
               chk("im_addr", 32'(im_addr), 32'(we_exp[41:32]));
               chk("im_wdata", im_wdata, we_exp[31:0]);
            end
         end
         if (pc_we) begin
            chk("retire_pending", 32'(rq.size() > 0), 1);
            if (rq.size() > 0) begin
               rt_exp = rq.pop_front();
               chk("retire_pc", cur_pc, rt_exp);
            end
         end
      end
   end

   task automatic load_word(input logic [31:0] a, input logic [31:0] d, input logic last);
      int n = 0;
      if (a[31:12] == '0) wq.push_back({a[11:2], d});
      ld_addr = a; ld_data = d; ld_last = last; ld_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!ld_ready && n < 10);
      chk("ld_ready", 32'(ld_ready), 1);
      chk("im_we_range", 32'(im_we), 32'(a[31:12] == '0));
      @(posedge clk); #1;
      ld_valid = 1'b0; ld_last = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_state(input logic [1:0] s, input int maxc, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (state !== s && n < maxc);
      chk(tag, 32'(state), 32'(s));
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0;
      ld_valid = 1'b0; ld_last = 1'b0; ld_addr = '0; ld_data = '0;
      #2 rst = 1'b0;
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_count", instr_count, 0);
      chk("rst_ld_ready", 32'(ld_ready), 0);
      chk("rst_pc_we", 32'(pc_we), 0);
      chk("rst_pc_init", 32'(pc_init), 0);
      chk("rst_flags", 32'({halted, timeout, ld_err}), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // program: three plain words then the halt word at word 3
      load_word(32'h0, 32'h1111_0001, 1'b0);
      load_word(32'h4, 32'h1111_0002, 1'b0);
      load_word(32'h8, 32'h1111_0003, 1'b0);
      load_word(32'hC, HALT_W, 1'b1);
      chk("load_idle", 32'(state), 0);
      chk("load_drained", 32'(wq.size()), 0);
      chk("load_no_err", 32'(ld_err), 0);

      load_word(32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
      chk("range_err", 32'(ld_err), 1);
      chk("range_idle", 32'(state), 0);

      rq.push_back(32'h3000); rq.push_back(32'h3004); rq.push_back(32'h3008);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("init_state", 32'(state), 2);
      chk("init_pc_init", 32'(pc_init), 1);
      chk("init_pc_we", 32'(pc_we), 0);
      wait_state(2'b11, 20, "t4_halt");
      chk("t4_count", instr_count, 3);
      chk("t4_pc", cur_pc, 32'h300C);
      chk("t4_halted", 32'(halted), 1);
      chk("t4_timeout", 32'(timeout), 0);
      chk("t4_retired", 32'(rq.size()), 0);

      @(posedge clk); #1;
      rq.push_back(32'h3000); rq.push_back(32'h3004); rq.push_back(32'h3008);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (cur_pc == 32'h300C) break;
      end
      chk("t5_at_halt_word", cur_pc, 32'h300C);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_stall_pc_we", 32'(pc_we), 0);
         chk("t5_stall_state", 32'(state), 2);
      end
      @(posedge clk); #1;
      stall = 1'b0;
      @(negedge clk);
      chk("t5_halt_pc_we", 32'(pc_we), 0);
      @(negedge clk);
      chk("t5_halt_state", 32'(state), 3);
      chk("t5_count", instr_count, 3);

      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) load_word(32'(i * 4), 32'h100 + 32'(i), 1'(i == 9));
      chk("t6_loaded", 32'(wq.size()), 0);
      for (int i = 0; i < 8; i++) rq.push_back(RESET_PC + 32'(i * 4));
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_state(2'b11, 40, "t6_halt");
      chk("t6_timeout", 32'(timeout), 1);
      chk("t6_count", instr_count, 8);
      chk("t6_pc", cur_pc, 32'h3020);
      chk("t6_ld_err_sticky", 32'(ld_err), 1);

      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) rq.push_back(RESET_PC + 32'(i * 4));
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("restart_count", instr_count, 0);
      chk("restart_timeout", 32'(timeout), 0);
      chk("restart_state", 32'(state), 2);
      repeat (2) @(posedge clk);
      #1;

      rst = 1'b0;
      #1;
      chk("t1_state", 32'(state), 0);
      chk("t1_pc_we", 32'(pc_we), 0);
      chk("t1_pc_init", 32'(pc_init), 0);
      chk("t1_ld_ready", 32'(ld_ready), 0);
      chk("t1_count", instr_count, 0);
      chk("t1_ld_err", 32'(ld_err), 0);
      rq.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", 32'(state), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
